// File: rtl/irq_controller.sv
// Vectored interrupt controller: latches edge/level requests, arbitrates by fixed priority,
// presents a vector to the PC mux and keeps a return-address/priority stack for nesting.
module irq_controller #(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'('h3F0),
  parameter int unsigned VEC_STRIDE = 2,
  parameter int unsigned NEST_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(NEST_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_SRC-1:0]  i_src,
  input  logic [N_SRC-1:0]  i_edge_mode,
  input  logic              i_mask_we,
  input  logic [N_SRC-1:0]  i_mask_wd,
  input  logic              i_gie,
  input  logic              i_irq_ack,
  input  logic              i_reti,
  input  logic [ADDR_W-1:0] i_pc_ret,
  output logic              o_irq,
  output logic [ADDR_W-1:0] o_vec_addr,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic [3:0]        o_active_id,
  output logic [LVL_W-1:0]  o_nest_lvl,
  output logic [N_SRC-1:0]  o_pending,
  output logic              o_lost
);

  localparam logic [3:0] ID_NONE = 4'hF;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_SRC-1:0]   r_src_q;
  logic [N_SRC-1:0]   r_mask;
  logic [N_SRC-1:0]   r_pending;
  logic               r_lost;
  logic               r_irq;
  logic [3:0]         r_req_id;
  logic [ADDR_W-1:0]  r_vec_addr;
  logic [3:0]         r_active_id;
  logic [LVL_W-1:0]   r_nest_lvl;
  logic [ADDR_W-1:0]  r_ret_addr;
  logic [ADDR_W-1:0]  r_stk_addr [NEST_DEPTH];
  logic [3:0]         r_stk_id   [NEST_DEPTH];

  logic [N_SRC-1:0]   w_event;
  logic [N_SRC-1:0]   w_clr;
  logic               w_cand_vld;
  logic [3:0]         w_cand_id;
  logic [ADDR_W-1:0]  w_cand_vec;
  logic               w_req_ok;
  logic               w_load_req;
  logic               w_push;
  logic               w_pop;

  // Edge sources fire on a 0->1 transition, level sources every cycle they are high
  assign w_event = i_src & (~i_edge_mode | ~r_src_q);

  // Lowest enabled pending index wins
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_id  = ID_NONE;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (r_pending[i] && r_mask[i]) begin
        w_cand_vld = 1'b1;
        w_cand_id  = 4'(i);
      end
    end
  end

  assign w_cand_vec = VEC_BASE + ADDR_W'(32'(w_cand_id) * VEC_STRIDE);
  assign w_req_ok   = i_gie && w_cand_vld
                   && ((r_active_id == ID_NONE) || (w_cand_id < r_active_id))
                   && (r_nest_lvl < LVL_W'(NEST_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_ok) w_state_nxt = S_REQ;
      S_REQ:  if (i_irq_ack || !i_gie) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ack wins over a simultaneous reti; reti on an empty stack is dropped
  always_comb begin
    w_load_req = (r_state == S_IDLE) && w_req_ok;
    w_push     = (r_state == S_REQ) && i_irq_ack;
    w_pop      = i_reti && !w_push && (r_nest_lvl != '0);
    w_clr      = w_push ? (N_SRC'(1) << r_req_id) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src_q   <= '0;
      r_mask    <= '0;
      r_pending <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_src_q   <= i_src;
      if (i_mask_we) r_mask <= i_mask_wd;
      r_pending <= (r_pending & ~w_clr) | w_event;
      if (|(w_event & r_pending & ~w_clr)) r_lost <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq      <= 1'b0;
      r_req_id   <= '0;
      r_vec_addr <= VEC_BASE;
    end else begin
      r_irq <= (w_state_nxt == S_REQ);
      if (w_load_req) begin
        r_req_id   <= w_cand_id;
        r_vec_addr <= w_cand_vec;
      end
    end
  end

  // Return stack; r_ret_addr mirrors the top entry so it is ready during the reti cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_active_id <= ID_NONE;
      r_nest_lvl  <= '0;
      r_ret_addr  <= '0;
      for (int k = 0; k < int'(NEST_DEPTH); k++) begin
        r_stk_addr[k] <= '0;
        r_stk_id[k]   <= ID_NONE;
      end
    end else if (w_push) begin
      for (int k = 0; k < int'(NEST_DEPTH); k++) begin
        if (k == int'(r_nest_lvl)) begin
          r_stk_addr[k] <= i_pc_ret;
          r_stk_id[k]   <= r_active_id;
        end
      end
      r_active_id <= r_req_id;
      r_nest_lvl  <= r_nest_lvl + LVL_W'(1);
      r_ret_addr  <= i_pc_ret;
    end else if (w_pop) begin
      r_nest_lvl <= r_nest_lvl - LVL_W'(1);
      r_ret_addr <= '0;
      for (int k = 0; k < int'(NEST_DEPTH); k++) begin
        if (k == int'(r_nest_lvl) - 1) r_active_id <= r_stk_id[k];
        if (k == int'(r_nest_lvl) - 2) r_ret_addr  <= r_stk_addr[k];
      end
    end
  end

  assign o_irq       = r_irq;
  assign o_vec_addr  = r_vec_addr;
  assign o_ret_addr  = r_ret_addr;
  assign o_active_id = r_active_id;
  assign o_nest_lvl  = r_nest_lvl;
  assign o_pending   = r_pending;
  assign o_lost      = r_lost;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Parametrised vectored interrupt controller for the single-cycle processor datapath. It replaces the fixed interruption unit. It latches requests from N_SRC sources, each in edge or level mode, with a per-source mask and fixed priority. It presents a vector address to the PC mux and keeps a return-address/priority stack for nested preemption. The control unit drives irq_ack when it loads the vector into the PC and reti on return-from-interrupt.

Parameters:
N_SRC, 4, number of request sources (1..15)
ADDR_W, 10, program address width
VEC_BASE, 10'h3F0, address of the source-0 vector
VEC_STRIDE, 2, address distance between consecutive vectors
NEST_DEPTH, 4, maximum nesting levels (return stack depth)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
src  in  N_SRC  raw request lines, synchronous to clk
edge_mode  in  N_SRC  per source: 1 = rising-edge sensitive, 0 = level sensitive
mask_we  in  1  write enable for mask register
mask_wd  in  N_SRC  new mask value (1 = enabled)
gie  in  1  global interrupt enable
irq_ack  in  1  CPU loaded vec_addr into PC this cycle
reti  in  1  CPU executes return-from-interrupt this cycle
pc_ret  in  ADDR_W  return address pushed on irq_ack
irq  out  1  interrupt request to control unit (registered)
vec_addr  out  ADDR_W  vector address, stable while irq=1
ret_addr  out  ADDR_W  top-of-stack return address (0 when stack empty)
active_id  out  4  source in service; 4'hF = none
nest_lvl  out  $clog2(NEST_DEPTH)+1  current stack occupancy
pending  out  N_SRC  pending register
lost  out  1  sticky: request arrived while its pending bit was already set

Behaviour:
- Reset (clk edge with reset=1): pending=0, mask=0, src_q=0, irq=0, vec_addr=VEC_BASE, ret_addr=0, active_id=4'hF, nest_lvl=0, lost=0, state IDLE, stack cleared.
- Reset overrides everything, including mid-REQ and nested service.
- src_q resets to 0, so an edge-mode line already high after reset registers one edge.
- Event detection: edge-mode event = src & ~src_q; level-mode event = src.
- An event sets pending[i] at the next clk edge.
- If pending[i] is already 1 and not being cleared that cycle, the event sets lost.
- Masking never clears pending. A mask write takes effect on the following cycle.
- Candidate: the lowest index i with pending[i] & mask[i]. Index 0 has the highest priority.
- Request condition: gie & candidate valid & (active_id==4'hF or candidate < active_id) & nest_lvl < NEST_DEPTH.
- FSM IDLE: when the request condition holds, go to REQ at the next edge. Register irq=1, req_id=candidate and vec_addr = VEC_BASE + req_id*VEC_STRIDE (truncated to ADDR_W).
- Latency: src edge sampled at edge t; pending=1 after t+1; irq=1 after t+2.
- FSM REQ: req_id and vec_addr are frozen. Higher-priority arrivals wait until after the ack.
- REQ, irq_ack=1:
  - push {pc_ret, active_id}; active_id=req_id; nest_lvl+1; pending[req_id]=0.
  - If a new event for req_id occurs in the same cycle, set wins: pending stays 1 and lost is not set.
  - irq=0; return to IDLE.
- REQ, irq_ack=0 and gie=0: withdraw (irq=0, go to IDLE). pending is unchanged.
- reti with nest_lvl>0: pop the stack, restore active_id from the saved entry, nest_lvl-1. ret_addr shows the new top, or 0 when empty.
- reti with nest_lvl=0 is ignored.
- irq_ack and reti in the same cycle: ack is processed, reti is ignored.
- irq_ack outside REQ is ignored.
- ret_addr is valid combinationally from the top-of-stack register during the reti cycle, so the PC mux can use it that same cycle.
- Level-mode source still high after ack: pending re-sets on the next cycle. It preempts only under the priority rule, so a same-priority source is not re-requested until its reti.

Test Plan:
1. Basic vector: after reset, write mask=4'b1111, gie=1, raise src[2] at edge 5. Expect pending[2]=1 after edge 6, irq=1 and vec_addr=10'h3F4 after edge 7. Ack with pc_ret=10'h123. Expect irq=0, pending[2]=0, active_id=2, nest_lvl=1, ret_addr=10'h123.
2. Preemption and unwind: continue from scenario 1 with a src[0] edge. Expect vec_addr=10'h3F0; ack with pc_ret=10'h200 gives nest_lvl=2. First reti: ret_addr=10'h123, active_id=2. Second reti: nest_lvl=0, active_id=4'hF, ret_addr=0.
3. Priority block: with active_id=1, a src[3] edge sets pending[3] but irq stays 0. After reti, irq=1 with vec_addr=10'h3F6.
4. Level mode and withdraw:
   - Set edge_mode[1]=0 and hold src[1]=1. After ack, pending[1] returns to 1 the next cycle with no irq; irq reasserts after reti.
   - Separately, drop gie during REQ: irq falls and pending is kept.
5. Lost/collision: two src[3] edges before ack set lost=1, and it stays set until reset. An edge on src[2] in the same cycle as its ack leaves pending[2]=1 with lost=0.
6. Depth and reset: with NEST_DEPTH=2, nest sources 2 then 1; a src[0] edge gives no irq until one reti. Assert reset while in REQ: all outputs return to reset values the next cycle.
